gcd_run_controller: RTL
=======================

// Module: gcd_run_controller
// PURPOSE
//  Sequences one GCD computation per host command. On CMD_GO it snapshots the operands (ARG_LATCH) and starts the core
//  (GCD_START). It then waits for DONE with a blanking window and timeout, and captures the results (RES_CAPTURE).
//  It reports completion via sticky IRQ/STATUS, a cycle count and a run counter. Sits between the SRAM-mapped
//  register file and the GCD core, alongside the argument/result unpacker.
// PARAMETERS
//  CNT_W    32  width of CYCLES counter
//  TIMEOUT  32'd1000000  max WAIT cycles before timeout; 0 disables timeout
//  BLANK    2   initial WAIT cycles in which DONE is ignored (masks stale DONE from previous run); 0..15
// PORTS
//  CLK          in   1      clock, all logic rising-edge
//  RESETn       in   1      asynchronous active-low reset
//  CMD_GO       in   1      one-cycle start request from register file
//  CMD_ABORT    in   1      one-cycle abort request
//  IRQ_CLR      in   1      one-cycle clear of IRQ
//  DONE         in   1      GCD core done (level)
//  ARG_LATCH    out  1      one-cycle pulse: operand registers capture ARG_A/ARG_B
//  GCD_START    out  1      one-cycle start pulse to GCD core
//  RES_CAPTURE  out  1      one-cycle pulse: result registers capture RESULT_A/RESULT_B
//  BUSY         out  1      high whenever state != IDLE
//  IRQ          out  1      sticky completion interrupt
//  STATUS       out  2      00 none, 01 ok, 10 timeout, 11 aborted
//  CYCLES       out  CNT_W  WAIT cycles of current/last run
//  RUN_ID       out  8      count of successful (01) runs, wraps 255->0
// BEHAVIOUR
//  - Reset (async): state IDLE; every output 0 (STATUS=00, CYCLES=0, RUN_ID=0). Release synchronised by upstream.
//  - Moore FSM, one-hot or binary; pulses decoded from registered state; all outputs glitch-free registered.
//  - IDLE: CMD_GO -> LATCH; same edge clears IRQ, sets STATUS=00. CMD_ABORT/IRQ_CLR otherwise only act per rules below.
//  - LATCH (1 cyc): ARG_LATCH=1; CYCLES<=0 -> START.
//  - START (1 cyc): GCD_START=1; blank counter<=BLANK -> WAIT.
//  - WAIT: every cycle CYCLES<=CYCLES+1 (saturate at all-ones); blank counter decrements to 0.
//    Exit priority, evaluated on pre-increment values:
//    1) CMD_ABORT -> IDLE, STATUS=11, IRQ=1;
//    2) DONE && blank==0 -> CAPTURE;
//    3) TIMEOUT!=0 && CYCLES==TIMEOUT-1 -> IDLE, STATUS=10, IRQ=1.
//    The exit cycle still increments CYCLES, so timeout leaves CYCLES=TIMEOUT.
//  - CAPTURE (1 cyc): RES_CAPTURE=1 -> IDLE; on exit STATUS=01, IRQ=1, RUN_ID+1 (mod 256).
//  - CMD_ABORT in LATCH or START: -> IDLE, STATUS=11, IRQ=1, no GCD_START/RES_CAPTURE afterwards. CMD_ABORT in CAPTURE ignored.
//  - CMD_GO when state != IDLE: ignored, no queuing.
//  - IRQ_CLR clears IRQ; if IRQ set and clear coincide, set wins. STATUS/CYCLES hold until next CMD_GO.
//  - Latency: GO at edge c0 -> ARG_LATCH c1, GCD_START c2, first WAIT c3, earliest accepted DONE c3+BLANK,
//    RES_CAPTURE one cycle after accepted DONE, IRQ/STATUS the cycle after that.
// TESTING
//  (BLANK=2, TIMEOUT=16 unless noted; cycle numbers relative to CMD_GO edge c0)
//  1 GO, DONE rises c8 -> ARG_LATCH c1, GCD_START c2, RES_CAPTURE c9, IRQ=1 STATUS=01 CYCLES=6 RUN_ID=1 at c10, BUSY c1..c9.
//  2 DONE held high from before GO -> ignored c3,c4; accepted c5; CYCLES=3; RES_CAPTURE c6.
//  3 DONE never -> IDLE after 16 WAIT cycles, STATUS=10, CYCLES=16, IRQ=1, no RES_CAPTURE, RUN_ID unchanged; TIMEOUT=0 -> waits indefinitely.
//  4 ABORT and DONE same WAIT cycle -> STATUS=11, no RES_CAPTURE. ABORT in START -> no WAIT entered. ABORT in IDLE -> no change.
//  5 GO during WAIT ignored (single RES_CAPTURE). IRQ_CLR on IRQ-set cycle -> IRQ=1. Next GO clears IRQ. 256 successful runs -> RUN_ID=0.
//  6 RESETn low mid-WAIT -> all outputs 0 immediately (async); after release GO runs case 1 timing exactly.

Source files
------------

// File: rtl/gcd_run_controller.sv
// rtl/gcd_run_controller.sv - per-command GCD run sequencer
// Latches operands, starts the core, waits for DONE (blanked, with timeout), captures results, and reports status.
module gcd_run_controller #(
    parameter int          CNT_W   = 32,
    parameter logic [31:0] TIMEOUT = 32'd1000000,
    parameter logic [3:0]  BLANK   = 4'd2
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             CMD_GO,
    input  logic             CMD_ABORT,
    input  logic             IRQ_CLR,
    input  logic             DONE,
    output logic             ARG_LATCH,
    output logic             GCD_START,
    output logic             RES_CAPTURE,
    output logic             BUSY,
    output logic             IRQ,
    output logic [1:0]       STATUS,
    output logic [CNT_W-1:0] CYCLES,
    output logic [7:0]       RUN_ID
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_START,
        S_WAIT,
        S_CAPTURE
    } state_e;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_OK      = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    localparam bit              TIMEOUT_EN   = (TIMEOUT != 32'd0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 32'd1);

    state_e           state_q, state_d;
    logic [3:0]       blank_q, blank_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [1:0]       status_q, status_d;
    logic [7:0]       run_id_q, run_id_d;
    logic             irq_q, irq_d;
    logic             arg_latch_q, arg_latch_d;
    logic             gcd_start_q, gcd_start_d;
    logic             res_capture_q, res_capture_d;
    logic             busy_q, busy_d;
    logic             irq_set, irq_clr;

    always_comb begin
        state_d  = state_q;
        blank_d  = blank_q;
        cycles_d = cycles_q;
        status_d = status_q;
        run_id_d = run_id_q;
        irq_set  = 1'b0;
        irq_clr  = IRQ_CLR;

        case (state_q)
            S_IDLE: begin
                if (CMD_GO) begin
                    state_d  = S_LATCH;
                    status_d = ST_NONE;
                    irq_clr  = 1'b1;
                end
            end
            S_LATCH: begin
                cycles_d = '0;
                if (CMD_ABORT) begin
                    state_d  = S_IDLE;
                    status_d = ST_ABORT;
                    irq_set  = 1'b1;
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                blank_d = BLANK;
                if (CMD_ABORT) begin
                    state_d  = S_IDLE;
                    status_d = ST_ABORT;
                    irq_set  = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Exit decisions use pre-increment values; the exit cycle still counts.
                if (cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
                if (blank_q != 4'd0) blank_d = blank_q - 4'd1;
                if (CMD_ABORT) begin
                    state_d  = S_IDLE;
                    status_d = ST_ABORT;
                    irq_set  = 1'b1;
                end else if (DONE && (blank_q == 4'd0)) begin
                    state_d = S_CAPTURE;
                end else if (TIMEOUT_EN && (cycles_q == TIMEOUT_LAST)) begin
                    state_d  = S_IDLE;
                    status_d = ST_TIMEOUT;
                    irq_set  = 1'b1;
                end
            end
            S_CAPTURE: begin
                state_d  = S_IDLE;
                status_d = ST_OK;
                irq_set  = 1'b1;
                run_id_d = run_id_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase

        irq_d         = irq_set | (irq_q & ~irq_clr);
        // Pulses are flopped from the next state so they coincide with the state itself.
        arg_latch_d   = (state_d == S_LATCH);
        gcd_start_d   = (state_d == S_START);
        res_capture_d = (state_d == S_CAPTURE);
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q       <= S_IDLE;
            blank_q       <= 4'd0;
            cycles_q      <= '0;
            status_q      <= ST_NONE;
            run_id_q      <= 8'd0;
            irq_q         <= 1'b0;
            arg_latch_q   <= 1'b0;
            gcd_start_q   <= 1'b0;
            res_capture_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            blank_q       <= blank_d;
            cycles_q      <= cycles_d;
            status_q      <= status_d;
            run_id_q      <= run_id_d;
            irq_q         <= irq_d;
            arg_latch_q   <= arg_latch_d;
            gcd_start_q   <= gcd_start_d;
            res_capture_q <= res_capture_d;
            busy_q        <= busy_d;
        end
    end

    assign ARG_LATCH   = arg_latch_q;
    assign GCD_START   = gcd_start_q;
    assign RES_CAPTURE = res_capture_q;
    assign BUSY        = busy_q;
    assign IRQ         = irq_q;
    assign STATUS      = status_q;
    assign CYCLES      = cycles_q;
    assign RUN_ID      = run_id_q;

endmodule
